// File: rtl/vending_fsm_ctrl.sv
// Vending controller: edge-detected buttons/coins drive a one-hot FSM; money updates one clock after the input edge.
// No backpressure; a multiplexed 7-seg scan is registered. LEADING_ZERO_BLANK_EN blanks money leading zeros.
module vending_fsm_ctrl #(
  parameter int SCAN_DIV    = 100000,
  parameter int HIGH_WEIGHT = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       sys_Goods,
  input  logic       sys_Confirm,
  input  logic       sys_Change,
  input  logic       sys_Cancel,
  input  logic       in_money_one,
  input  logic       in_money_five,
  input  logic       in_money_ten,
  input  logic       in_money_twenty,
  input  logic       in_money_fifty,
  input  logic [2:0] type_SW_high,
  input  logic [2:0] type_SW_low,
  input  logic [1:0] num_SW,
  output logic [7:0] Bit_select,
  output logic [7:0] Seg_select,
  output logic [7:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [5:0] state_out
);

  localparam logic [5:0] S_IDLE   = 6'b000001;
  localparam logic [5:0] S_SELECT = 6'b000010;
  localparam logic [5:0] S_PAY    = 6'b000100;
  localparam logic [5:0] S_CHANGE = 6'b001000;
  localparam logic [5:0] S_REFUND = 6'b010000;
  localparam logic [5:0] S_FINISH = 6'b100000;

  localparam int          CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [15:0] HW = 16'(HIGH_WEIGHT);

  logic [5:0]  state;
  logic [8:0]  in_vec, prev_vec, edge_vec;
  logic        goods_e, confirm_e, change_e, cancel_e;
  logic [15:0] item_amt, coin_sum;
  logic [7:0]  need_add, input_add;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {9'd0, a} + {1'b0, b};
    return (s > 17'd255) ? 8'hFF : s[7:0];
  endfunction

  // Largest payout coin that still fits in what is owed
  function automatic logic [7:0] payout_coin(input logic [7:0] v);
    if (v >= 8'd50)      return 8'd50;
    else if (v >= 8'd20) return 8'd20;
    else if (v >= 8'd10) return 8'd10;
    else if (v >= 8'd5)  return 8'd5;
    else if (v >= 8'd1)  return 8'd1;
    else                 return 8'd0;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign in_vec = {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one,
                   sys_Cancel, sys_Change, sys_Confirm, sys_Goods};
  assign edge_vec  = in_vec & ~prev_vec;
  assign goods_e   = edge_vec[0];
  assign confirm_e = edge_vec[1];
  assign change_e  = edge_vec[2];
  assign cancel_e  = edge_vec[3];

  assign item_amt = (16'(type_SW_high) * HW + 16'(type_SW_low)) * 16'(num_SW);
  assign coin_sum = (edge_vec[4] ? 16'd1  : 16'd0) + (edge_vec[5] ? 16'd5  : 16'd0) +
                    (edge_vec[6] ? 16'd10 : 16'd0) + (edge_vec[7] ? 16'd20 : 16'd0) +
                    (edge_vec[8] ? 16'd50 : 16'd0);
  assign need_add  = sat_add(need_money, item_amt);
  assign input_add = sat_add(input_money, coin_sum);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev_vec     <= '0;
      state        <= S_IDLE;
      need_money   <= '0;
      input_money  <= '0;
      change_money <= '0;
    end else begin
      prev_vec <= in_vec;
      case (state)
        S_IDLE: begin
          if (confirm_e) begin
            state        <= S_SELECT;
            need_money   <= '0;
            input_money  <= '0;
            change_money <= '0;
          end
        end
        S_SELECT: begin
          if (cancel_e) begin
            change_money <= input_money;
            need_money   <= '0;
            state        <= S_REFUND;
          end else if (confirm_e) begin
            need_money <= need_add;
            if (need_add != 8'd0) state <= S_PAY;
          end else if (goods_e) begin
            need_money <= need_add;
          end
        end
        S_PAY: begin
          if (cancel_e) begin
            change_money <= input_money;
            need_money   <= '0;
            state        <= S_REFUND;
          end else begin
            // Coins landing on the confirm edge count toward the payment
            input_money <= input_add;
            if (confirm_e && input_add >= need_money) begin
              change_money <= input_add - need_money;
              state        <= S_CHANGE;
            end
          end
        end
        S_CHANGE, S_REFUND: begin
          if (change_money == 8'd0)
            state <= S_FINISH;
          else if (change_e)
            change_money <= change_money - payout_coin(change_money);
        end
        S_FINISH: begin
          if (change_e || confirm_e) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_out = state;

  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit_idx;
  logic [7:0]    disp_val, money_sel, state_idx, seg_next;
  logic [1:0]    place;
  logic          is_money, blank;
  logic [3:0]    digit_val;

  always_comb begin
    state_idx = 8'd0;
    case (state)
      S_SELECT: state_idx = 8'd1;
      S_PAY:    state_idx = 8'd2;
      S_CHANGE: state_idx = 8'd3;
      S_REFUND: state_idx = 8'd4;
      S_FINISH: state_idx = 8'd5;
      default:  state_idx = 8'd0;
    endcase
  end

  assign money_sel = (state == S_CHANGE || state == S_REFUND || state == S_FINISH) ?
                     change_money : need_money;

  always_comb begin
    disp_val = state_idx;
    place    = 2'd0;
    is_money = 1'b0;
    case (digit_idx)
      3'd0, 3'd1, 3'd2: begin
        disp_val = input_money;
        place    = digit_idx[1:0];
        is_money = 1'b1;
      end
      3'd3, 3'd4, 3'd5: begin
        disp_val = money_sel;
        place    = 2'(digit_idx - 3'd3);
        is_money = 1'b1;
      end
      3'd6:    place = 2'd0;
      default: place = 2'd1;
    endcase

    case (place)
      2'd0:    digit_val = 4'(disp_val % 8'd10);
      2'd1:    digit_val = 4'((disp_val / 8'd10) % 8'd10);
      default: digit_val = 4'(disp_val / 8'd100);
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    blank = is_money && ((place == 2'd2 && disp_val < 8'd100) ||
                         (place == 2'd1 && disp_val < 8'd10));
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 8'hFF : seg_code(digit_val);
  end

  // Segments and digit enable are registered together so they stay aligned
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      Bit_select <= 8'hFE;
      Seg_select <= 8'hFF;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      Bit_select <= ~(8'd1 << digit_idx);
      Seg_select <= seg_next;
    end
  end

endmodule

// File: tb/tb_vending_fsm_ctrl.sv
// Directed bench for vending_fsm_ctrl: selection, payment, change, refund, saturation, display scan.
module tb_vending_fsm_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [8:0] btn;
  logic [2:0] hi, lo;
  logic [1:0] num;
  logic [7:0] Bit_select, Seg_select, need_money, input_money, change_money;
  logic [5:0] state_out;
  int checks = 0;
  int errors = 0;

  localparam logic [8:0] B_GOODS = 9'h001, B_CONF = 9'h002, B_CHG = 9'h004, B_CAN = 9'h008;
  localparam logic [8:0] B_1 = 9'h010, B_5 = 9'h020, B_10 = 9'h040, B_20 = 9'h080, B_50 = 9'h100;

  always #5 sys_clk = ~sys_clk;

  vending_fsm_ctrl #(.SCAN_DIV(4), .HIGH_WEIGHT(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sys_Goods(btn[0]), .sys_Confirm(btn[1]), .sys_Change(btn[2]), .sys_Cancel(btn[3]),
    .in_money_one(btn[4]), .in_money_five(btn[5]), .in_money_ten(btn[6]),
    .in_money_twenty(btn[7]), .in_money_fifty(btn[8]),
    .type_SW_high(hi), .type_SW_low(lo), .num_SW(num),
    .Bit_select(Bit_select), .Seg_select(Seg_select),
    .need_money(need_money), .input_money(input_money), .change_money(change_money),
    .state_out(state_out)
  );

  task automatic press(input logic [8:0] m, input int hold);
    @(negedge sys_clk);
    btn = m;
    repeat (hold) @(negedge sys_clk);
    btn = '0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; btn = '0; hi = '0; lo = '0; num = '0;
    repeat (3) @(negedge sys_clk);
    checks++; if (state_out !== 6'b000001) begin errors++; $display("FAIL rst_state got %b want 000001", state_out); end
    checks++; if (need_money !== 8'd0 || input_money !== 8'd0 || change_money !== 8'd0) begin
      errors++; $display("FAIL rst_money got %0d/%0d/%0d want 0/0/0", need_money, input_money, change_money); end
    checks++; if (Bit_select !== 8'hFE) begin errors++; $display("FAIL rst_bit got %h want fe", Bit_select); end
    checks++; if (Seg_select !== 8'hFF) begin errors++; $display("FAIL rst_seg got %h want ff", Seg_select); end
    sys_rst = 1'b0;
  endtask

  task automatic test_select();
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b000010 || need_money !== 8'd0) begin
      errors++; $display("FAIL sel_enter got %b need %0d want 000010 need 0", state_out, need_money); end
    num = 2'd0; hi = 3'd2;
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b000010) begin errors++; $display("FAIL sel_zero_confirm got %b want 000010", state_out); end
    hi = 3'd2; lo = 3'd1; num = 2'd3;
    press(B_GOODS, 1);
    checks++; if (need_money !== 8'd33 || state_out !== 6'b000010) begin
      errors++; $display("FAIL sel_goods got need %0d st %b want 33 000010", need_money, state_out); end
    hi = 3'd3; lo = 3'd3; num = 2'd1;
    press(B_GOODS | B_CONF, 1);
    checks++; if (need_money !== 8'd51 || state_out !== 6'b000100) begin
      errors++; $display("FAIL sel_confirm got need %0d st %b want 51 000100", need_money, state_out); end
  endtask

  task automatic test_pay();
    press(B_1 | B_5, 1);
    checks++; if (input_money !== 8'd6) begin errors++; $display("FAIL pay_sim_coins got %0d want 6", input_money); end
    press(B_GOODS, 1);
    checks++; if (need_money !== 8'd51) begin errors++; $display("FAIL pay_goods_ignored got %0d want 51", need_money); end
    press(B_10, 1); press(B_20, 1); press(B_50, 1);
    checks++; if (input_money !== 8'd86) begin errors++; $display("FAIL pay_total got %0d want 86", input_money); end
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b001000 || change_money !== 8'd35) begin
      errors++; $display("FAIL pay_confirm got st %b chg %0d want 001000 35", state_out, change_money); end
  endtask

  task automatic test_display();
    logic [7:0] exp_seg [8];
    logic [7:0] want_bit;
    int t;
    exp_seg = '{8'h82, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h92, 8'hC0};
`ifdef LEADING_ZERO_BLANK_EN
    exp_seg[2] = 8'hFF; exp_seg[4] = 8'hFF; exp_seg[5] = 8'hFF;
`endif
    for (int d = 0; d < 8; d++) begin
      want_bit = ~(8'd1 << d);
      t = 0;
      while (Bit_select !== want_bit && t < 40) begin
        @(negedge sys_clk);
        t++;
      end
      checks++;
      if (t >= 40 || Seg_select !== exp_seg[d]) begin
        errors++; $display("FAIL disp_digit%0d got bit %h seg %h want bit %h seg %h", d, Bit_select, Seg_select, want_bit, exp_seg[d]);
      end
    end
  endtask

  task automatic test_change();
    press(B_CHG, 1);
    checks++; if (change_money !== 8'd15) begin errors++; $display("FAIL chg_1 got %0d want 15", change_money); end
    press(B_CHG, 1);
    checks++; if (change_money !== 8'd5) begin errors++; $display("FAIL chg_2 got %0d want 5", change_money); end
    press(B_CHG, 1);
    checks++; if (change_money !== 8'd0 || state_out !== 6'b001000) begin
      errors++; $display("FAIL chg_3 got %0d st %b want 0 001000", change_money, state_out); end
    @(negedge sys_clk);
    checks++; if (state_out !== 6'b100000) begin errors++; $display("FAIL chg_finish got %b want 100000", state_out); end
    test_display();
    press(B_CHG, 1);
    checks++; if (state_out !== 6'b000001) begin errors++; $display("FAIL chg_idle got %b want 000001", state_out); end
  endtask

  task automatic test_refund();
    press(B_CONF, 1);
    checks++; if (input_money !== 8'd0 || state_out !== 6'b000010) begin
      errors++; $display("FAIL ref_clear got in %0d st %b want 0 000010", input_money, state_out); end
    hi = 3'd3; lo = 3'd2; num = 2'd3;
    press(B_CONF, 1);
    press(B_20, 1);
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b000100 || input_money !== 8'd20 || need_money !== 8'd51) begin
      errors++; $display("FAIL ref_short_confirm got st %b in %0d need %0d want 000100 20 51", state_out, input_money, need_money); end
    press(B_CAN | B_50, 1);
    checks++; if (state_out !== 6'b010000 || change_money !== 8'd20 || need_money !== 8'd0 || input_money !== 8'd20) begin
      errors++; $display("FAIL ref_cancel got st %b chg %0d need %0d in %0d want 010000 20 0 20",
                         state_out, change_money, need_money, input_money); end
    press(B_CHG, 1);
    checks++; if (change_money !== 8'd0) begin errors++; $display("FAIL ref_payout got %0d want 0", change_money); end
    @(negedge sys_clk);
    checks++; if (state_out !== 6'b100000) begin errors++; $display("FAIL ref_finish got %b want 100000", state_out); end
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b000001) begin errors++; $display("FAIL ref_idle got %b want 000001", state_out); end
  endtask

  task automatic test_saturation();
    press(B_50, 1);
    checks++; if (input_money !== 8'd20) begin errors++; $display("FAIL sat_idle_coin got %0d want 20", input_money); end
    press(B_CONF, 1);
    hi = 3'd7; lo = 3'd7; num = 2'd3;
    press(B_GOODS, 1);
    press(B_GOODS, 1);
    checks++; if (need_money !== 8'd252) begin errors++; $display("FAIL sat_need_252 got %0d want 252", need_money); end
    press(B_CONF, 1);
    checks++; if (need_money !== 8'd255 || state_out !== 6'b000100) begin
      errors++; $display("FAIL sat_need got %0d st %b want 255 000100", need_money, state_out); end
    press(B_50, 5);
    checks++; if (input_money !== 8'd50) begin errors++; $display("FAIL sat_held_coin got %0d want 50", input_money); end
    for (int i = 0; i < 4; i++) press(B_50, 1);
    checks++; if (input_money !== 8'd250) begin errors++; $display("FAIL sat_in_250 got %0d want 250", input_money); end
    press(B_50, 1);
    checks++; if (input_money !== 8'd255) begin errors++; $display("FAIL sat_in got %0d want 255", input_money); end
    press(B_CONF, 1);
    checks++; if (state_out !== 6'b001000 || change_money !== 8'd0) begin
      errors++; $display("FAIL sat_exact got st %b chg %0d want 001000 0", state_out, change_money); end
    @(negedge sys_clk);
    checks++; if (state_out !== 6'b100000) begin errors++; $display("FAIL sat_finish got %b want 100000", state_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_select();
    test_pay();
    test_change();
    test_refund();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
